// File: rtl/banner_slide_ctrl.sv
// Slides the "DRAW" banner up from below the screen, holds it at TARGET_Y and releases it on dismiss.
// Optional macro BANNER_BLINK_EN makes the banner blink while it is held.
module banner_slide_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int TEXT_W       = 124,
  parameter int TARGET_Y     = 220,
  parameter int SLIDE_STEP   = 8,
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_PERIOD = 30
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic        show_req_i,
  input  logic        dismiss_i,
  output logic [31:0] start_x_o,
  output logic [31:0] start_y_o,
  output logic        banner_on_o,
  output logic        busy_o,
  output logic        hold_done_o
);

  typedef enum logic [1:0] {IDLE, SLIDE, HOLD} state_e;

  localparam int HoldW = $clog2(HOLD_FRAMES + 1);
  localparam logic [31:0] YOff  = 32'(SCREEN_H);
  localparam logic [31:0] YRest = 32'(TARGET_Y);
  localparam logic [31:0] YStep = 32'(SLIDE_STEP);
  // Snapping once within one step of the rest row keeps the subtraction from underflowing.
  localparam logic [31:0] YSnap = 32'(TARGET_Y + SLIDE_STEP);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

  if (BLINK_PERIOD < 2 || (BLINK_PERIOD % 2) != 0) begin : g_bad_blink_period
    $error("BLINK_PERIOD must be even and at least 2");
  end

  state_e            state_q, state_d;
  logic [31:0]       start_y_q, start_y_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              banner_on_q, banner_on_d;
  logic              busy_q, busy_d;
  logic              hold_done_q, hold_done_d;

`ifdef BANNER_BLINK_EN
  localparam int BlinkW = $clog2(BLINK_PERIOD + 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_PERIOD - 1);
  localparam logic [BlinkW-1:0] BlinkHalf = BlinkW'(BLINK_PERIOD / 2);
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      start_y_q   <= YOff;
      hold_cnt_q  <= '0;
      banner_on_q <= 1'b0;
      busy_q      <= 1'b0;
      hold_done_q <= 1'b0;
`ifdef BANNER_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      start_y_q   <= start_y_d;
      hold_cnt_q  <= hold_cnt_d;
      banner_on_q <= banner_on_d;
      busy_q      <= busy_d;
      hold_done_q <= hold_done_d;
`ifdef BANNER_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    start_y_d  = start_y_q;
    hold_cnt_d = hold_cnt_q;
`ifdef BANNER_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        start_y_d  = YOff;
        hold_cnt_d = '0;
        if (show_req_i) state_d = SLIDE;
      end
      SLIDE: begin
        if (frame_tick_i) begin
          if (start_y_q <= YSnap) begin
            start_y_d  = YRest;
            hold_cnt_d = '0;
`ifdef BANNER_BLINK_EN
            blink_cnt_d = '0;
`endif
            state_d    = HOLD;
          end else begin
            start_y_d = start_y_q - YStep;
          end
        end
      end
      HOLD: begin
        start_y_d = YRest;
        // Dismiss takes priority over a coincident frame tick.
        if (dismiss_i && hold_done_q) begin
          start_y_d  = YOff;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (frame_tick_i) begin
          if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + 1'b1;
`ifdef BANNER_BLINK_EN
          blink_cnt_d = (blink_cnt_q == BlinkLast) ? '0 : blink_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        start_y_d = YOff;
      end
    endcase
  end

  always_comb begin
    busy_d      = (state_d != IDLE);
    hold_done_d = (state_d == HOLD) && (hold_cnt_d == HoldMax);
`ifdef BANNER_BLINK_EN
    banner_on_d = (state_d == SLIDE) || ((state_d == HOLD) && (blink_cnt_d < BlinkHalf));
`else
    banner_on_d = (state_d != IDLE);
`endif
  end

  assign start_x_o   = 32'((SCREEN_W - TEXT_W) / 2);
  assign start_y_o   = start_y_q;
  assign banner_on_o = banner_on_q;
  assign busy_o      = busy_q;
  assign hold_done_o = hold_done_q;

endmodule

// File: tb/tb_banner_slide_ctrl.sv
// Bench for banner_slide_ctrl: scoreboard of expected start_y per frame tick plus direct output checks.
module tb_banner_slide_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        frame_tick_i = 1'b0;
  logic        show_req_i = 1'b0;
  logic        dismiss_i = 1'b0;
  logic [31:0] start_x_o;
  logic [31:0] start_y_o;
  logic        banner_on_o;
  logic        busy_o;
  logic        hold_done_o;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  banner_slide_ctrl dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .frame_tick_i(frame_tick_i),
    .show_req_i  (show_req_i),
    .dismiss_i   (dismiss_i),
    .start_x_o   (start_x_o),
    .start_y_o   (start_y_o),
    .banner_on_o (banner_on_o),
    .busy_o      (busy_o),
    .hold_done_o (hold_done_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock; single-cycle pulses are dropped right after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    frame_tick_i = 1'b0;
    show_req_i   = 1'b0;
    dismiss_i    = 1'b0;
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    step();
  endtask

  function automatic logic exp_banner(int n);
`ifdef BANNER_BLINK_EN
    return ((n % 30) < 15);
`else
    return 1'b1;
`endif
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    step();
    total++; if (start_y_o !== 32'd480) begin bad++; $display("FAIL reset_start_y got=%0d want=480", start_y_o); end
    total++; if (banner_on_o !== 1'b0) begin bad++; $display("FAIL reset_banner_on got=%b want=0", banner_on_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (hold_done_o !== 1'b0) begin bad++; $display("FAIL reset_hold_done got=%b want=0", hold_done_o); end
    total++; if (start_x_o !== 32'd258) begin bad++; $display("FAIL reset_start_x got=%0d want=258", start_x_o); end
  endtask

  task automatic test_slide();
    int e;
    show_req_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL slide_busy got=%b want=1", busy_o); end
    total++; if (banner_on_o !== 1'b1) begin bad++; $display("FAIL slide_banner_on got=%b want=1", banner_on_o); end
    total++; if (start_y_o !== 32'd480) begin bad++; $display("FAIL slide_start got=%0d want=480", start_y_o); end
    for (int k = 1; k <= 33; k++) begin
      exp_q.push_back((k < 33) ? (480 - 8 * k) : 220);
      tick();
      e = exp_q.pop_front();
      total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL slide_tick%0d got=%0d want=%0d", k, start_y_o, e); end
      for (int g = 0; g < 9; g++) begin
        step();
        total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL slide_between%0d got=%0d want=%0d", k, start_y_o, e); end
      end
    end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL hold_entry_busy got=%b want=1", busy_o); end
    total++; if (banner_on_o !== 1'b1) begin bad++; $display("FAIL hold_entry_banner got=%b want=1", banner_on_o); end
    total++; if (hold_done_o !== 1'b0) begin bad++; $display("FAIL hold_entry_done got=%b want=0", hold_done_o); end
  endtask

  task automatic test_early_dismiss();
    for (int n = 1; n <= 100; n++) begin
      tick();
      step();
      total++; if (banner_on_o !== exp_banner(n)) begin bad++; $display("FAIL blink_tick%0d got=%b want=%b", n, banner_on_o, exp_banner(n)); end
    end
    dismiss_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL early_dismiss_busy got=%b want=1", busy_o); end
    total++; if (start_y_o !== 32'd220) begin bad++; $display("FAIL early_dismiss_y got=%0d want=220", start_y_o); end
    step();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL early_dismiss_queued got=%b want=1", busy_o); end
    for (int n = 101; n <= 179; n++) begin
      tick();
      step();
      total++; if (banner_on_o !== exp_banner(n)) begin bad++; $display("FAIL blink_tick%0d got=%b want=%b", n, banner_on_o, exp_banner(n)); end
    end
    total++; if (hold_done_o !== 1'b0) begin bad++; $display("FAIL hold_done_179 got=%b want=0", hold_done_o); end
    tick();
    total++; if (hold_done_o !== 1'b1) begin bad++; $display("FAIL hold_done_180 got=%b want=1", hold_done_o); end
    for (int n = 181; n <= 200; n++) begin
      tick();
      total++; if (banner_on_o !== exp_banner(n)) begin bad++; $display("FAIL blink_tick%0d got=%b want=%b", n, banner_on_o, exp_banner(n)); end
      total++; if (hold_done_o !== 1'b1) begin bad++; $display("FAIL hold_done_sat%0d got=%b want=1", n, hold_done_o); end
    end
    dismiss_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL dismiss_busy got=%b want=0", busy_o); end
    total++; if (start_y_o !== 32'd480) begin bad++; $display("FAIL dismiss_y got=%0d want=480", start_y_o); end
    total++; if (banner_on_o !== 1'b0) begin bad++; $display("FAIL dismiss_banner got=%b want=0", banner_on_o); end
    total++; if (hold_done_o !== 1'b0) begin bad++; $display("FAIL dismiss_hold_done got=%b want=0", hold_done_o); end
  endtask

  task automatic test_simultaneous();
    int e;
    show_req_i   = 1'b1;
    frame_tick_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL simul_busy got=%b want=1", busy_o); end
    for (int g = 0; g < 3; g++) begin
      total++; if (start_y_o !== 32'd480) begin bad++; $display("FAIL simul_hold480 got=%0d want=480", start_y_o); end
      step();
    end
    exp_q.push_back(472);
    tick();
    e = exp_q.pop_front();
    total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL simul_first got=%0d want=%0d", start_y_o, e); end
    show_req_i = 1'b1;
    step();
    total++; if (start_y_o !== 32'd472) begin bad++; $display("FAIL restart_ignored got=%0d want=472", start_y_o); end
    exp_q.push_back(464);
    tick();
    e = exp_q.pop_front();
    total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL restart_traj got=%0d want=%0d", start_y_o, e); end
  endtask

  task automatic test_reset_mid_slide();
    int e;
    for (int k = 1; k <= 14; k++) begin
      exp_q.push_back(464 - 8 * k);
      tick();
      step();
      e = exp_q.pop_front();
      total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL midslide_tick%0d got=%0d want=%0d", k, start_y_o, e); end
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    total++; if (start_y_o !== 32'd480) begin bad++; $display("FAIL midreset_y got=%0d want=480", start_y_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy_o); end
    total++; if (banner_on_o !== 1'b0) begin bad++; $display("FAIL midreset_banner got=%b want=0", banner_on_o); end
    dismiss_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_dismiss got=%b want=0", busy_o); end
    show_req_i = 1'b1;
    step();
    total++; if (start_y_o !== 32'd480 || busy_o !== 1'b1) begin bad++; $display("FAIL reslide_start y=%0d busy=%b want 480/1", start_y_o, busy_o); end
    exp_q.push_back(472);
    tick();
    e = exp_q.pop_front();
    total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL reslide_tick got=%0d want=%0d", start_y_o, e); end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int e;
    show_req_i = 1'b1;
    step();
    repeat (33) begin tick(); step(); end
    repeat (180) begin tick(); step(); end
    total++; if (hold_done_o !== 1'b1) begin bad++; $display("FAIL b2b_hold_done got=%b want=1", hold_done_o); end
    dismiss_i    = 1'b1;
    frame_tick_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_dismiss_wins got=%b want=0", busy_o); end
    total++; if (start_y_o !== 32'd480) begin bad++; $display("FAIL b2b_dismiss_y got=%0d want=480", start_y_o); end
    show_req_i = 1'b1;
    step();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy_o); end
    exp_q.push_back(472);
    tick();
    e = exp_q.pop_front();
    total++; if (start_y_o !== 32'(e)) begin bad++; $display("FAIL b2b_tick got=%0d want=%0d", start_y_o, e); end
  endtask

  initial begin
    test_reset();
    test_slide();
    test_early_dismiss();
    test_simultaneous();
    test_reset_mid_slide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
